// File: rtl/l1_l2_arbiter_pkg.sv
// rtl/l1_l2_arbiter_pkg.sv - shared widths and FSM encoding for the L1/L2 arbiter
//
// Purpose: single home for the cache line/address widths and the arbiter
//          state encoding used by every file of the arbiter.
// Ports:   none (package).
package l1_l2_arbiter_pkg;

  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/l2_arb_timeout.sv
// rtl/l2_arb_timeout.sv - 8-bit WAIT-phase watchdog counter for the L1/L2 arbiter
//
// Purpose: counts cycles while enabled and flags the cycle in which the count
//          would reach TIMEOUT.
// Ports:
//   clk     in  clock
//   rst     in  asynchronous active-low reset
//   clear   in  zero the count (held while the arbiter is outside WAIT)
//   enable  in  count this cycle
//   expired out high in the enabled cycle whose edge brings the count to TIMEOUT
module l2_arb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Decoding one below TIMEOUT lets the FSM leave WAIT on the same edge
  // at which the count reaches TIMEOUT.
  assign expired = enable && (r_count == LP_LAST);

endmodule

// File: rtl/l1_l2_arbiter.sv
// rtl/l1_l2_arbiter.sv - arbitrates icache and dcache line requests onto one L2 port
//
// Purpose: IDLE/REQ/WAIT/DONE FSM granting the L2 port to one cache at a time,
//          alternating on ties, with a WAIT watchdog and sticky timeout flag.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   irq, ic_addr                 icache fill request and line address
//   drq, dc_addr, dc_rw, dc_wd   dcache request, address, direction, write line
//   l2_rdy, l2_done, err_clr     L2 accept, L2 completion pulse, error clear
//   l2_req, l2_addr, l2_rw, l2_wd  latched request presented to L2
//   ic_grant, dc_grant           owner indication for the whole transaction
//   ic_done, dc_done             one-cycle completion pulse to the owner
//   timeout_err                  sticky watchdog abort flag
module l1_l2_arbiter
  import l1_l2_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              irq,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              drq,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_rw,
  input  logic [LINE_W-1:0] dc_wd,
  input  logic              l2_rdy,
  input  logic              l2_done,
  input  logic              err_clr,
  output logic              l2_req,
  output logic [ADDR_W-1:0] l2_addr,
  output logic              l2_rw,
  output logic [LINE_W-1:0] l2_wd,
  output logic              ic_grant,
  output logic              dc_grant,
  output logic              ic_done,
  output logic              dc_done,
  output logic              timeout_err
);

  arb_state_e        r_state, w_state_nxt;
  logic              r_l2_req, w_l2_req_nxt;
  logic [ADDR_W-1:0] r_l2_addr, w_l2_addr_nxt;
  logic              r_l2_rw, w_l2_rw_nxt;
  logic [LINE_W-1:0] r_l2_wd, w_l2_wd_nxt;
  logic              r_ic_grant, w_ic_grant_nxt;
  logic              r_dc_grant, w_dc_grant_nxt;
  logic              r_ic_done, w_ic_done_nxt;
  logic              r_dc_done, w_dc_done_nxt;
  logic              r_timeout_err, w_err_set;
  logic              r_last_dc, w_last_dc_nxt;
  logic              w_pick_dc;
  logic              w_expired;

  l2_arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (r_state != ST_WAIT),
    .enable  (r_state == ST_WAIT),
    .expired (w_expired)
  );

  // dcache wins when alone, or on a tie when icache owned the port last.
  assign w_pick_dc = drq && (!irq || !r_last_dc);

  always_comb begin
    w_state_nxt    = r_state;
    w_l2_req_nxt   = r_l2_req;
    w_l2_addr_nxt  = r_l2_addr;
    w_l2_rw_nxt    = r_l2_rw;
    w_l2_wd_nxt    = r_l2_wd;
    w_ic_grant_nxt = r_ic_grant;
    w_dc_grant_nxt = r_dc_grant;
    w_ic_done_nxt  = 1'b0;
    w_dc_done_nxt  = 1'b0;
    w_last_dc_nxt  = r_last_dc;
    w_err_set      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (irq || drq) begin
          w_state_nxt   = ST_REQ;
          w_l2_req_nxt  = 1'b1;
          w_last_dc_nxt = w_pick_dc;
          if (w_pick_dc) begin
            w_l2_addr_nxt  = dc_addr;
            w_l2_rw_nxt    = dc_rw;
            w_l2_wd_nxt    = dc_rw ? dc_wd : '0;
            w_dc_grant_nxt = 1'b1;
          end else begin
            w_l2_addr_nxt  = ic_addr;
            w_l2_rw_nxt    = 1'b0;
            w_l2_wd_nxt    = '0;
            w_ic_grant_nxt = 1'b1;
          end
        end
      end
      ST_REQ: begin
        // l2_done is deliberately not looked at until WAIT.
        if (l2_rdy) begin
          w_state_nxt  = ST_WAIT;
          w_l2_req_nxt = 1'b0;
        end
      end
      ST_WAIT: begin
        if (l2_done || w_expired) begin
          w_state_nxt   = ST_DONE;
          w_ic_done_nxt = r_ic_grant;
          w_dc_done_nxt = r_dc_grant;
          w_err_set     = !l2_done;
        end
      end
      ST_DONE: begin
        w_state_nxt    = ST_IDLE;
        w_ic_grant_nxt = 1'b0;
        w_dc_grant_nxt = 1'b0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_l2_req      <= 1'b0;
      r_l2_addr     <= '0;
      r_l2_rw       <= 1'b0;
      r_l2_wd       <= '0;
      r_ic_grant    <= 1'b0;
      r_dc_grant    <= 1'b0;
      r_ic_done     <= 1'b0;
      r_dc_done     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_last_dc     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_l2_req      <= w_l2_req_nxt;
      r_l2_addr     <= w_l2_addr_nxt;
      r_l2_rw       <= w_l2_rw_nxt;
      r_l2_wd       <= w_l2_wd_nxt;
      r_ic_grant    <= w_ic_grant_nxt;
      r_dc_grant    <= w_dc_grant_nxt;
      r_ic_done     <= w_ic_done_nxt;
      r_dc_done     <= w_dc_done_nxt;
      r_last_dc     <= w_last_dc_nxt;
      // A set in the same cycle as a clear takes priority.
      r_timeout_err <= w_err_set || (r_timeout_err && !err_clr);
    end
  end

  assign l2_req      = r_l2_req;
  assign l2_addr     = r_l2_addr;
  assign l2_rw       = r_l2_rw;
  assign l2_wd       = r_l2_wd;
  assign ic_grant    = r_ic_grant;
  assign dc_grant    = r_dc_grant;
  assign ic_done     = r_ic_done;
  assign dc_done     = r_dc_done;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// tb/tb_l1_l2_arbiter.sv - directed self-checking bench for l1_l2_arbiter
module tb_l1_l2_arbiter;

  localparam logic [127:0] LINE_A5 = {16{8'hA5}};

  logic         clk;
  logic         rst;
  logic         irq;
  logic [27:0]  ic_addr;
  logic         drq;
  logic [27:0]  dc_addr;
  logic         dc_rw;
  logic [127:0] dc_wd;
  logic         l2_rdy;
  logic         l2_done;
  logic         err_clr;
  logic         l2_req;
  logic [27:0]  l2_addr;
  logic         l2_rw;
  logic [127:0] l2_wd;
  logic         ic_grant;
  logic         dc_grant;
  logic         ic_done;
  logic         dc_done;
  logic         timeout_err;

  int n_cmp;
  int n_bad;

  l1_l2_arbiter #(
    .TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .irq         (irq),
    .ic_addr     (ic_addr),
    .drq         (drq),
    .dc_addr     (dc_addr),
    .dc_rw       (dc_rw),
    .dc_wd       (dc_wd),
    .l2_rdy      (l2_rdy),
    .l2_done     (l2_done),
    .err_clr     (err_clr),
    .l2_req      (l2_req),
    .l2_addr     (l2_addr),
    .l2_rw       (l2_rw),
    .l2_wd       (l2_wd),
    .ic_grant    (ic_grant),
    .dc_grant    (dc_grant),
    .ic_done     (ic_done),
    .dc_done     (dc_done),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives REQ -> WAIT -> DONE; returns with the DUT in its DONE cycle.
  task automatic complete_txn();
    l2_rdy = 1'b1;
    tick();
    l2_rdy = 1'b0;
    l2_done = 1'b1;
    tick();
    l2_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    irq = 0; drq = 0; ic_addr = '0; dc_addr = '0; dc_rw = 0; dc_wd = '0;
    l2_rdy = 0; l2_done = 0; err_clr = 0;
    tick(); tick();
    n_cmp++; if ({l2_req, l2_addr, l2_rw, l2_wd, ic_grant, dc_grant, ic_done, dc_done, timeout_err} !== '0) begin n_bad++; $display("FAIL reset_outputs act_req=%0h act_addr=%0h act_gnt=%0h%0h exp all zero", l2_req, l2_addr, ic_grant, dc_grant); end
    rst = 1'b1;
    tick();
    n_cmp++; if (l2_req !== 1'b0) begin n_bad++; $display("FAIL reset_idle_req act=%0h exp=0", l2_req); end
  endtask

  task automatic test_icache_fill();
    irq = 1'b1; ic_addr = 28'h0000040;
    tick();
    n_cmp++; if (l2_req !== 1'b1) begin n_bad++; $display("FAIL ic_l2_req act=%0h exp=1", l2_req); end
    n_cmp++; if (l2_addr !== 28'h40) begin n_bad++; $display("FAIL ic_l2_addr act=%0h exp=40", l2_addr); end
    n_cmp++; if ({l2_rw, ic_grant, dc_grant} !== 3'b010) begin n_bad++; $display("FAIL ic_rw_grants act=%b exp=010", {l2_rw, ic_grant, dc_grant}); end
    tick();
    n_cmp++; if (l2_req !== 1'b1) begin n_bad++; $display("FAIL ic_req_hold act=%0h exp=1", l2_req); end
    l2_rdy = 1'b1;
    tick();
    l2_rdy = 1'b0;
    n_cmp++; if ({l2_req, ic_grant} !== 2'b01) begin n_bad++; $display("FAIL ic_wait act=%b exp=01", {l2_req, ic_grant}); end
    l2_done = 1'b1;
    tick();
    l2_done = 1'b0; irq = 1'b0;
    n_cmp++; if ({ic_done, dc_done, ic_grant} !== 3'b101) begin n_bad++; $display("FAIL ic_done_pulse act=%b exp=101", {ic_done, dc_done, ic_grant}); end
    tick();
    n_cmp++; if ({ic_done, ic_grant, l2_req} !== 3'b000) begin n_bad++; $display("FAIL ic_after_done act=%b exp=000", {ic_done, ic_grant, l2_req}); end
    tick();
    n_cmp++; if (l2_req !== 1'b0) begin n_bad++; $display("FAIL ic_no_rerequest act=%0h exp=0", l2_req); end
  endtask

  task automatic test_tie();
    rst = 1'b0; tick(); rst = 1'b1;
    irq = 1; drq = 1; ic_addr = 28'h0000222; dc_addr = 28'h0000111; dc_rw = 0;
    tick();
    n_cmp++; if ({ic_grant, dc_grant} !== 2'b01 || l2_addr !== 28'h111) begin n_bad++; $display("FAIL tie_first_dc act_gnt=%b act_addr=%0h exp_gnt=01 exp_addr=111", {ic_grant, dc_grant}, l2_addr); end
    complete_txn();
    n_cmp++; if ({ic_done, dc_done} !== 2'b01) begin n_bad++; $display("FAIL tie_dc_done act=%b exp=01", {ic_done, dc_done}); end
    tick();
    n_cmp++; if ({ic_grant, dc_grant, ic_done, dc_done} !== 4'b0000) begin n_bad++; $display("FAIL tie_idle act=%b exp=0000", {ic_grant, dc_grant, ic_done, dc_done}); end
    tick();
    n_cmp++; if ({ic_grant, dc_grant} !== 2'b10 || l2_addr !== 28'h222) begin n_bad++; $display("FAIL tie_second_ic act_gnt=%b act_addr=%0h exp_gnt=10 exp_addr=222", {ic_grant, dc_grant}, l2_addr); end
    complete_txn();
    n_cmp++; if ({ic_done, dc_done} !== 2'b10) begin n_bad++; $display("FAIL tie_ic_done act=%b exp=10", {ic_done, dc_done}); end
    tick(); tick();
    n_cmp++; if ({ic_grant, dc_grant} !== 2'b01) begin n_bad++; $display("FAIL tie_third_dc act=%b exp=01", {ic_grant, dc_grant}); end
    complete_txn();
    irq = 0; drq = 0;
    tick();
  endtask

  task automatic test_writeback();
    drq = 1; dc_rw = 1; dc_addr = 28'hABCDEF0; dc_wd = LINE_A5;
    tick();
    n_cmp++; if (l2_rw !== 1'b1 || l2_wd !== LINE_A5) begin n_bad++; $display("FAIL wb_latch act_rw=%0h act_wd=%0h exp_rw=1 exp_wd=%0h", l2_rw, l2_wd, LINE_A5); end
    l2_rdy = 1;
    tick();
    l2_rdy = 0; dc_wd = '0; dc_addr = 28'h1234567; dc_rw = 0;
    tick();
    n_cmp++; if (l2_wd !== LINE_A5 || l2_addr !== 28'hABCDEF0 || l2_rw !== 1'b1) begin n_bad++; $display("FAIL wb_stable act_wd=%0h act_addr=%0h act_rw=%0h exp_addr=abcdef0", l2_wd, l2_addr, l2_rw); end
    l2_done = 1;
    tick();
    l2_done = 0; drq = 0;
    n_cmp++; if (dc_done !== 1'b1 || l2_wd !== LINE_A5) begin n_bad++; $display("FAIL wb_done act_done=%0h act_wd=%0h exp_done=1", dc_done, l2_wd); end
    tick();
    drq = 1; dc_rw = 0; dc_wd = LINE_A5; dc_addr = 28'h0000055;
    tick();
    n_cmp++; if (l2_rw !== 1'b0 || l2_wd !== '0 || l2_addr !== 28'h55) begin n_bad++; $display("FAIL fill_wd_zero act_rw=%0h act_wd=%0h act_addr=%0h exp=0/0/55", l2_rw, l2_wd, l2_addr); end
    complete_txn();
    drq = 0;
    tick();
  endtask

  task automatic test_timeout();
    drq = 1; dc_rw = 0;
    tick();
    l2_rdy = 1;
    tick();
    l2_rdy = 0;
    repeat (3) tick();
    n_cmp++; if ({timeout_err, dc_done, dc_grant} !== 3'b001) begin n_bad++; $display("FAIL to_before act=%b exp=001", {timeout_err, dc_done, dc_grant}); end
    tick();
    n_cmp++; if ({timeout_err, dc_done} !== 2'b11) begin n_bad++; $display("FAIL to_expire act=%b exp=11", {timeout_err, dc_done}); end
    drq = 0;
    tick();
    n_cmp++; if ({timeout_err, dc_done} !== 2'b10) begin n_bad++; $display("FAIL to_sticky act=%b exp=10", {timeout_err, dc_done}); end
    err_clr = 1;
    tick();
    err_clr = 0;
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_clear act=%0h exp=0", timeout_err); end
    drq = 1;
    tick();
    l2_rdy = 1;
    tick();
    l2_rdy = 0; err_clr = 1;
    repeat (4) tick();
    drq = 0;
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_set_wins act=%0h exp=1", timeout_err); end
    tick();
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_clear_after act=%0h exp=0", timeout_err); end
    err_clr = 0;
  endtask

  task automatic test_reset_mid();
    drq = 1; dc_rw = 1; dc_wd = LINE_A5; dc_addr = 28'h0000077;
    tick();
    l2_rdy = 1;
    tick();
    l2_rdy = 0;
    #1 rst = 1'b0;
    #1;
    n_cmp++; if ({l2_req, l2_addr, l2_rw, l2_wd, ic_grant, dc_grant, ic_done, dc_done, timeout_err} !== '0) begin n_bad++; $display("FAIL rst_mid_async act_gnt=%b act_addr=%0h act_wd=%0h exp all zero", {ic_grant, dc_grant}, l2_addr, l2_wd); end
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if ({l2_req, dc_grant} !== 2'b11 || l2_addr !== 28'h77) begin n_bad++; $display("FAIL rst_mid_regrant act=%b act_addr=%0h exp=11/77", {l2_req, dc_grant}, l2_addr); end
    complete_txn();
    drq = 0;
    n_cmp++; if (dc_done !== 1'b1) begin n_bad++; $display("FAIL rst_mid_done act=%0h exp=1", dc_done); end
    tick();
  endtask

  task automatic test_rdy_done_same();
    drq = 1; dc_rw = 0;
    tick();
    l2_rdy = 1; l2_done = 1;
    tick();
    l2_rdy = 0; l2_done = 0;
    n_cmp++; if ({l2_req, dc_done, dc_grant} !== 3'b001) begin n_bad++; $display("FAIL same_enter_wait act=%b exp=001", {l2_req, dc_done, dc_grant}); end
    tick();
    n_cmp++; if ({dc_done, dc_grant} !== 2'b01) begin n_bad++; $display("FAIL same_still_wait act=%b exp=01", {dc_done, dc_grant}); end
    l2_done = 1;
    tick();
    l2_done = 0; drq = 0;
    n_cmp++; if (dc_done !== 1'b1) begin n_bad++; $display("FAIL same_done act=%0h exp=1", dc_done); end
    tick();
    n_cmp++; if ({dc_done, dc_grant} !== 2'b00) begin n_bad++; $display("FAIL same_idle act=%b exp=00", {dc_done, dc_grant}); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_icache_fill();
    test_tie();
    test_writeback();
    test_timeout();
    test_reset_mid();
    test_rdy_done_same();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/l1_l2_arbiter.md
L1_L2_ARBITER -- requirements
Module: l1_l2_arbiter

Interface
REQ-001 SHALL take parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles before abort (1..255).
REQ-002 SHALL have port clk  in  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have port irq  in  1  icache line-fill request.
REQ-005 SHALL have port ic_addr  in  28  icache line address.
REQ-006 SHALL have port drq  in  1  dcache request.
REQ-007 SHALL have port dc_addr  in  28  dcache line address.
REQ-008 SHALL have port dc_rw  in  1  dcache direction: 1 = write-back, 0 = fill.
REQ-009 SHALL have port dc_wd  in  128  dcache write-back line.
REQ-010 SHALL have port l2_rdy  in  1  L2 accepts the presented request.
REQ-011 SHALL have port l2_done  in  1  one-cycle pulse marking L2 transaction completion.
REQ-012 SHALL have port err_clr  in  1  clears timeout_err.
REQ-013 SHALL have port l2_req  out  1  request to L2.
REQ-014 SHALL have port l2_addr  out  28  latched address to L2.
REQ-015 SHALL have port l2_rw  out  1  latched direction to L2 (0 for icache).
REQ-016 SHALL have port l2_wd  out  128  latched write data (0 for icache or fill).
REQ-017 SHALL have ports ic_grant and dc_grant  out  1 each  owner indication, held for the whole transaction.
REQ-018 SHALL have ports ic_done and dc_done  out  1 each  one-cycle completion pulse to the owner.
REQ-019 SHALL have port timeout_err  out  1  sticky abort flag.

Function
REQ-020 SHALL implement the FSM states IDLE, REQ, WAIT and DONE, all outputs registered.
REQ-021 IDLE SHALL sample irq/drq; if either is high, it SHALL latch the winner's addr/rw/wd, set its grant and go to REQ on the next edge (1-cycle request-to-l2_req latency).
REQ-022 Arbitration SHALL give a single requester the grant; if both request, the requester not granted last SHALL win; the last-owner bit SHALL reset to "icache", so dcache wins the first tie.
REQ-023 REQ SHALL hold l2_req=1 until l2_rdy=1, then go to WAIT with l2_req=0; l2_done SHALL be ignored in REQ, including when it coincides with l2_rdy.
REQ-024 WAIT SHALL go to DONE on l2_done=1.
REQ-025 WAIT SHALL increment an 8-bit counter (cleared on WAIT entry) each cycle; when it reaches TIMEOUT without l2_done, the block SHALL set timeout_err and go to DONE.
REQ-026 DONE SHALL last exactly one cycle, pulse the owner's done output, clear both grants and return to IDLE.
REQ-027 Latched address and data SHALL stay stable from REQ through DONE; requester input changes during ownership SHALL be ignored.
REQ-028 The owner SHALL deassert its request on the edge ending DONE; a request still high in IDLE SHALL start a new transaction.
REQ-029 timeout_err SHALL be cleared by err_clr; if set and clear occur in the same cycle, set SHALL win.
REQ-030 At most one grant and at most one done output SHALL be high in any cycle.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE and zero all outputs, the counter and the latches, and set the last-owner bit to icache, including mid-transaction.

Structure
REQ-032 State encoding, the address width (28) and the line width (128) SHALL live in the shared cache header/package.
REQ-033 The timeout counter SHALL be a single sub-module named l2_arb_timeout (inputs: clear, enable; output: expired).

Verification
REQ-034 irq=1 with ic_addr=0x000_0040 -> l2_req=1, l2_addr=0x40, l2_rw=0, ic_grant=1 one cycle later; l2_rdy, then l2_done -> ic_done pulses for 1 cycle.
REQ-035 irq=drq=1 from reset -> dcache wins; on re-request after completion -> icache wins; the winner alternates while both are held.
REQ-036 drq=1, dc_rw=1, dc_wd=0xA5 repeated -> l2_rw=1, l2_wd=0xA5 repeated; dc_wd changed during WAIT -> l2_wd unchanged.
REQ-037 TIMEOUT=4 with l2_done withheld -> timeout_err=1 after 4 WAIT cycles and dc_done pulses; err_clr=1 -> timeout_err=0.
REQ-038 rst=0 while in WAIT -> all outputs are 0 immediately; after release, a pending drq is granted normally.
REQ-039 l2_rdy and l2_done both high in REQ -> state is WAIT, no done pulse.
